// File: rtl/irq_controller.sv
// Machine-level interrupt controller: edge-latched external sources plus a
// prescaled mtime/mtimecmp timer, masked and fixed-priority selected, with a
// request/service handshake toward the exception unit.
module irq_controller #(
   parameter int unsigned NSRC    = 4,
   parameter int unsigned PRESC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src,
   input  logic            mie,
   input  logic            trap_taken,
   input  logic            mret,
   input  logic            cfg_we,
   input  logic [2:0]      cfg_addr,
   input  logic [31:0]     cfg_wdata,
   output logic [31:0]     cfg_rdata,
   output logic            interrupt,
   output logic [3:0]      irq_id
);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e             state_q, state_d;
   logic [NSRC:0]      enable_q, enable_d;
   logic [NSRC:1]      pend_q, pend_d;
   logic [NSRC-1:0]    src_q;
   logic [31:0]        mtime_q, mtime_d;
   logic [31:0]        mtimecmp_q, mtimecmp_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic               interrupt_q, interrupt_d;
   logic [3:0]         irq_id_q, irq_id_d;

   logic               timer_hit;
   logic [NSRC:0]      pending;
   logic [NSRC:0]      active;
   logic [NSRC:1]      set_ev;
   logic [NSRC:1]      w1c;
   logic [NSRC:1]      trap_clr;
   logic [3:0]         winner_id;

   // Timer level is never latched; it tracks the compare continuously.
   assign timer_hit = (mtime_q >= mtimecmp_q);
   assign pending   = {pend_q, timer_hit};
   assign active    = pending & enable_q;
   assign set_ev    = irq_src & ~src_q;
   assign w1c       = (cfg_we && cfg_addr == 3'd1) ? cfg_wdata[NSRC:1] : '0;

   assign interrupt = interrupt_q;
   assign irq_id    = irq_id_q;

   // Fixed priority: lowest active index wins; id equals the pending bit index.
   always_comb begin
      winner_id = '0;
      for (int i = int'(NSRC); i >= 0; i--) begin
         if (active[i]) winner_id = 4'(i);
      end
   end

   // Config registers, timer and pending next-state.
   always_comb begin
      enable_d   = enable_q;
      mtimecmp_d = mtimecmp_q;
      presc_d    = presc_q;
      mtime_d    = mtime_q;
      cnt_d      = cnt_q + 1'b1;
      if (cnt_q >= presc_q) begin
         cnt_d   = '0;
         mtime_d = mtime_q + 32'd1;
      end
      if (cfg_we) begin
         unique case (cfg_addr)
            3'd0:    enable_d   = cfg_wdata[NSRC:0];
            3'd2:    mtime_d    = cfg_wdata;
            3'd3:    mtimecmp_d = cfg_wdata;
            3'd5:    presc_d    = cfg_wdata[PRESC_W-1:0];
            default: ;
         endcase
      end
      // A new edge outranks any clear in the same cycle.
      pend_d = (pend_q & ~w1c & ~trap_clr) | set_ev;
   end

   // Request/service FSM.
   always_comb begin
      state_d     = state_q;
      interrupt_d = interrupt_q;
      irq_id_d    = irq_id_q;
      trap_clr    = '0;
      unique case (state_q)
         StIdle: begin
            if (mie && |active) begin
               state_d     = StReq;
               interrupt_d = 1'b1;
               irq_id_d    = winner_id;
            end
         end
         StReq: begin
            if (trap_taken) begin
               state_d     = StService;
               interrupt_d = 1'b0;
               for (int i = 1; i <= int'(NSRC); i++) begin
                  trap_clr[i] = (irq_id_q == 4'(i));
               end
            end else if (!mie || !(|active)) begin
               state_d     = StIdle;
               interrupt_d = 1'b0;
            end else begin
               irq_id_d = winner_id;
            end
         end
         StService: begin
            interrupt_d = 1'b0;
            if (mret) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Combinational register read port.
   always_comb begin
      cfg_rdata = '0;
      unique case (cfg_addr)
         3'd0:    cfg_rdata[NSRC:0] = enable_q;
         3'd1:    cfg_rdata[NSRC:0] = pending;
         3'd2:    cfg_rdata = mtime_q;
         3'd3:    cfg_rdata = mtimecmp_q;
         3'd4:    cfg_rdata[3:0] = irq_id_q;
         3'd5:    cfg_rdata[PRESC_W-1:0] = presc_q;
         default: cfg_rdata = '0;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         enable_q    <= '0;
         pend_q      <= '0;
         src_q       <= '0;
         mtime_q     <= '0;
         mtimecmp_q  <= 32'hFFFF_FFFF;
         presc_q     <= '0;
         cnt_q       <= '0;
         interrupt_q <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         pend_q      <= pend_d;
         src_q       <= irq_src;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         interrupt_q <= interrupt_d;
         irq_id_q    <= irq_id_d;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  irq_src = '0;
   logic        mie = 1'b1;
   logic        trap_taken = 1'b0;
   logic        mret = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        interrupt;
   logic [3:0]  irq_id;

   int total = 0;
   int bad   = 0;

   irq_controller #(.NSRC(4), .PRESC_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_src    (irq_src),
      .mie        (mie),
      .trap_taken (trap_taken),
      .mret       (mret),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .interrupt  (interrupt),
      .irq_id     (irq_id)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic pulse_trap();
      trap_taken = 1'b1; step(); trap_taken = 1'b0;
   endtask

   task automatic pulse_mret();
      mret = 1'b1; step(); mret = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      step(); step();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_int got=%b exp=0", interrupt); end
      total++; if (irq_id !== 4'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", irq_id); end
      rd(3'd0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_enable got=%h exp=0", d); end
      rd(3'd1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_pending got=%h exp=0", d); end
      rd(3'd2, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mtime got=%h exp=0", d); end
      rd(3'd3, d); total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_mtimecmp got=%h exp=ffffffff", d); end
      rd(3'd5, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_presc got=%h exp=0", d); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      logic [31:0] d;
      wr(3'd0, 32'h2);
      irq_src[0] = 1'b1; step(); irq_src[0] = 1'b0;
      rd(3'd1, d); total++; if (d !== 32'h2) begin bad++; $display("FAIL t1_pending got=%h exp=2", d); end
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t1_int_early got=%b exp=0", interrupt); end
      step();
      total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL t1_int got=%b exp=1", interrupt); end
      total++; if (irq_id !== 4'd1) begin bad++; $display("FAIL t1_id got=%0d exp=1", irq_id); end
   endtask

   task automatic test_service();
      logic [31:0] d;
      pulse_trap();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t2_int got=%b exp=0", interrupt); end
      rd(3'd1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t2_pending got=%h exp=0", d); end
      rd(3'd4, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL t2_claim got=%h exp=1", d); end
      pulse_mret();
      step(); step();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t2_after_mret got=%b exp=0", interrupt); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      wr(3'd0, 32'h1F);
      // Sources 2 and 0 plus an expired timer, all in one cycle.
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 32'h0; irq_src = 4'b0101;
      step();
      cfg_we = 1'b0; irq_src = '0;
      step();
      total++; if (interrupt !== 1'b1 || irq_id !== 4'd0) begin bad++; $display("FAIL t3_first int=%b id=%0d exp int=1 id=0", interrupt, irq_id); end
      pulse_trap();
      rd(3'd1, d); total++; if (d !== 32'hB) begin bad++; $display("FAIL t3_pending got=%h exp=b", d); end
      wr(3'd3, 32'hFFFF_FFFF);
      pulse_mret();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t3_idle_gap got=%b exp=0", interrupt); end
      step();
      total++; if (interrupt !== 1'b1 || irq_id !== 4'd1) begin bad++; $display("FAIL t3_second int=%b id=%0d exp int=1 id=1", interrupt, irq_id); end
      pulse_trap(); pulse_mret(); step();
      total++; if (interrupt !== 1'b1 || irq_id !== 4'd3) begin bad++; $display("FAIL t3_third int=%b id=%0d exp int=1 id=3", interrupt, irq_id); end
      pulse_trap();
      rd(3'd1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t3_pending_end got=%h exp=0", d); end
      pulse_mret();
   endtask

   task automatic test_timer();
      logic [31:0] d;
      int n;
      wr(3'd5, 32'd3);
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd10);
      wr(3'd0, 32'h1);
      n = 0;
      while (interrupt !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      total++; if (n < 34 || n > 44) begin bad++; $display("FAIL t4_latency got=%0d exp=34..44", n); end
      wr(3'd5, 32'd0);
      wr(3'd2, 32'hFFFF_FFFF);
      rd(3'd2, d); total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL t4_mtime_max got=%h exp=ffffffff", d); end
      step();
      rd(3'd2, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t4_wrap got=%h exp=0", d); end
      rd(3'd1, d); total++; if (d[0] !== 1'b0) begin bad++; $display("FAIL t4_pend0 got=%b exp=0", d[0]); end
      step();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t4_int_drop got=%b exp=0", interrupt); end
      wr(3'd3, 32'hFFFF_FFFF);
      wr(3'd0, 32'h0);
   endtask

   task automatic test_mie_w1c();
      logic [31:0] d;
      mie = 1'b0;
      wr(3'd0, 32'h2);
      irq_src[0] = 1'b1; step(); irq_src[0] = 1'b0;
      step(); step();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t5_masked got=%b exp=0", interrupt); end
      mie = 1'b1;
      step();
      total++; if (interrupt !== 1'b1 || irq_id !== 4'd1) begin bad++; $display("FAIL t5_unmask int=%b id=%0d exp int=1 id=1", interrupt, irq_id); end
      wr(3'd1, 32'h2);
      rd(3'd1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t5_w1c got=%h exp=0", d); end
      step();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t5_drop got=%b exp=0", interrupt); end
   endtask

   task automatic test_set_beats_clear();
      logic [31:0] d;
      wr(3'd0, 32'h0);
      // Edge on src1 (pending bit 2) while W1C targets bits 1 and 2.
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'h6; irq_src[1] = 1'b1;
      step();
      cfg_we = 1'b0; irq_src[1] = 1'b0;
      rd(3'd1, d); total++; if (d !== 32'h4) begin bad++; $display("FAIL set_wins got=%h exp=4", d); end
   endtask

   task automatic test_reset_in_service();
      logic [31:0] d;
      wr(3'd5, 32'd5);
      wr(3'd0, 32'h4);
      step();
      total++; if (interrupt !== 1'b1 || irq_id !== 4'd2) begin bad++; $display("FAIL t6_req int=%b id=%0d exp int=1 id=2", interrupt, irq_id); end
      pulse_trap();
      irq_src[2] = 1'b1; step(); irq_src[2] = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++; if (interrupt !== 1'b0 || irq_id !== 4'd0) begin bad++; $display("FAIL t6_rst_out int=%b id=%0d exp 0 0", interrupt, irq_id); end
      rd(3'd0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t6_enable got=%h exp=0", d); end
      rd(3'd1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t6_pending got=%h exp=0", d); end
      rd(3'd5, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL t6_presc got=%h exp=0", d); end
      rd(3'd3, d); total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL t6_mtimecmp got=%h exp=ffffffff", d); end
      step();
      rst = 1'b0;
      step(); step();
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL t6_post got=%b exp=0", interrupt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_service();
      test_priority();
      test_timer();
      test_mie_w1c();
      test_set_beats_clear();
      test_reset_in_service();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
